// File: rtl/hamming_pkg.sv
// Shared Hamming-code helpers: position arithmetic, syndrome masks and data-bit map.
// Also used by the (7,4)+parity encoder so both ends agree on bit placement.
package hamming_pkg;

  localparam int unsigned MAX_CODE_W = 128;

  typedef enum logic [1:0] {
    CLS_CLEAN  = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_DOUBLE = 2'd2
  } err_cls_t;

  function automatic bit is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Bit i of the mask covers Hamming position i+1; parity bit k checks positions with bit k set.
  function automatic logic [MAX_CODE_W-1:0] syn_mask(input int unsigned k,
                                                     input int unsigned code_w);
    logic [MAX_CODE_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_CODE_W; i++) begin
      if ((i < code_w) && ((((i + 1) >> k) & 1) != 0)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Code-word bit index holding data bit j (non-power-of-two positions, ascending).
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 0;
    for (int unsigned i = 0; i < MAX_CODE_W; i++) begin
      if (!is_pow2(i + 1)) begin
        if (cnt == j) res = i;
        cnt++;
      end
    end
    return res;
  endfunction

  // Smallest positional parity count able to cover data_w bits.
  function automatic int unsigned par_w_for(input int unsigned data_w);
    int unsigned p;
    p = 0;
    for (int unsigned q = 31; q >= 1; q--) begin
      if ((1 << q) >= data_w + q + 1) p = q;
    end
    return p;
  endfunction

endpackage

// File: rtl/hamming_err_cnt.sv
// Saturating event counter with synchronous clear; clear wins over a same-cycle increment.
module hamming_err_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage streaming SECDED decoder: stage 1 computes syndrome and overall parity,
// stage 2 classifies, corrects and extracts data. Valid/ready with bubble collapsing.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned PAR_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_valid,
  output logic                     out_ready,
  input  logic [DATA_W+PAR_W-1:0]  in_code,
  input  logic                     in_parity,
  output logic                     out_valid,
  input  logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_err_single,
  output logic                     out_err_double,
  output logic [PAR_W-1:0]         out_syndrome,
  input  logic                     in_cnt_clr,
  output logic [CNT_W-1:0]         out_cnt_single,
  output logic [CNT_W-1:0]         out_cnt_double
);

  localparam int unsigned CODE_W = DATA_W + PAR_W;

  if (((1 << PAR_W) < CODE_W + 1) || (CODE_W > MAX_CODE_W)) begin : g_bad_params
    $error("hamming_secded_dec: PAR_W=%0d cannot cover DATA_W=%0d", PAR_W, DATA_W);
  end

  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic [PAR_W-1:0]  r_s1_syn;
  logic              r_s1_p;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_single;
  logic              r_s2_double;
  logic [PAR_W-1:0]  r_s2_syn;

  logic              w_s2_adv;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [PAR_W-1:0]  w_syn;
  logic              w_p;
  logic [CODE_W-1:0] w_flip;
  logic [CODE_W-1:0] w_fix;
  logic [CODE_W-1:0] w_corr;
  logic [DATA_W-1:0] w_data;
  err_cls_t          w_cls;

  assign w_s2_adv   = !r_s2_valid || in_ready;
  assign out_ready  = !r_s1_valid || w_s2_adv;
  assign w_in_fire  = in_valid && out_ready;
  assign w_out_fire = r_s2_valid && in_ready;

  for (genvar k = 0; k < PAR_W; k++) begin : g_syn
    localparam logic [MAX_CODE_W-1:0] MASK = syn_mask(k, CODE_W);
    assign w_syn[k] = ^(in_code & MASK[CODE_W-1:0]);
  end

  assign w_p = (^in_code) ^ in_parity;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
      r_s1_p     <= 1'b0;
    end else if (out_ready) begin
      r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_code <= in_code;
        r_s1_syn  <= w_syn;
        r_s1_p    <= w_p;
      end
    end
  end

  // One-hot of the position named by the syndrome; all-zero when it points past the word.
  for (genvar i = 0; i < CODE_W; i++) begin : g_flip
    assign w_flip[i] = (r_s1_syn == PAR_W'(i + 1));
  end

  always_comb begin
    w_cls = CLS_CLEAN;
    w_fix = '0;
    if (r_s1_syn == '0) begin
      if (r_s1_p) w_cls = CLS_SINGLE;
    end else if (r_s1_p && (32'(r_s1_syn) <= CODE_W)) begin
      w_cls = CLS_SINGLE;
      w_fix = w_flip;
    end else begin
      w_cls = CLS_DOUBLE;
    end
  end

  assign w_corr = r_s1_code ^ w_fix;

  for (genvar j = 0; j < DATA_W; j++) begin : g_ext
    localparam int unsigned POS = data_pos(j);
    assign w_data[j] = w_corr[POS];
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_s2_single <= 1'b0;
      r_s2_double <= 1'b0;
      r_s2_syn    <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data   <= w_data;
        r_s2_single <= (w_cls == CLS_SINGLE);
        r_s2_double <= (w_cls == CLS_DOUBLE);
        r_s2_syn    <= r_s1_syn;
      end
    end
  end

  assign out_valid      = r_s2_valid;
  assign out_data       = r_s2_data;
  assign out_err_single = r_s2_single;
  assign out_err_double = r_s2_double;
  assign out_syndrome   = r_s2_syn;

  // Counted on the output transfer, so a stalled word is counted exactly once.
  hamming_err_cnt #(.CNT_W(CNT_W)) u_cnt_single (
    .i_clk (in_clk),
    .i_rst (in_rst),
    .i_clr (in_cnt_clr),
    .i_inc (w_out_fire && r_s2_single),
    .o_cnt (out_cnt_single)
  );

  hamming_err_cnt #(.CNT_W(CNT_W)) u_cnt_double (
    .i_clk (in_clk),
    .i_rst (in_rst),
    .i_clr (in_cnt_clr),
    .i_inc (w_out_fire && r_s2_double),
    .o_cnt (out_cnt_double)
  );

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Scoreboard bench for hamming_secded_dec (DATA_W=4, PAR_W=3) plus a CNT_W=2 saturation instance.
module tb_hamming_secded_dec;

  typedef struct packed {
    logic [3:0] data;
    logic       single;
    logic       dbl;
    logic [2:0] syn;
  } exp_t;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready;
  logic [6:0]  in_code = '0;
  logic        in_parity = 1'b0;
  logic        out_valid;
  logic        in_ready = 1'b1;
  logic [3:0]  out_data;
  logic        out_err_single;
  logic        out_err_double;
  logic [2:0]  out_syndrome;
  logic        in_cnt_clr = 1'b0;
  logic [15:0] out_cnt_single;
  logic [15:0] out_cnt_double;

  logic        v2 = 1'b0;
  logic        rdy2;
  logic [6:0]  code2 = '0;
  logic        ovalid2;
  logic [3:0]  odata2;
  logic        osingle2;
  logic        odouble2;
  logic [2:0]  osyn2;
  logic [1:0]  cs2;
  logic [1:0]  cd2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t        q[$];

  always #5 in_clk = ~in_clk;

  hamming_secded_dec #(.DATA_W(4), .PAR_W(3), .CNT_W(16)) dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_code        (in_code),
    .in_parity      (in_parity),
    .out_valid      (out_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_err_single (out_err_single),
    .out_err_double (out_err_double),
    .out_syndrome   (out_syndrome),
    .in_cnt_clr     (in_cnt_clr),
    .out_cnt_single (out_cnt_single),
    .out_cnt_double (out_cnt_double)
  );

  hamming_secded_dec #(.DATA_W(4), .PAR_W(3), .CNT_W(2)) dut2 (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .in_valid       (v2),
    .out_ready      (rdy2),
    .in_code        (code2),
    .in_parity      (1'b0),
    .out_valid      (ovalid2),
    .in_ready       (1'b1),
    .out_data       (odata2),
    .out_err_single (osingle2),
    .out_err_double (odouble2),
    .out_syndrome   (osyn2),
    .in_cnt_clr     (1'b0),
    .out_cnt_single (cs2),
    .out_cnt_double (cd2)
  );

  task automatic chk(input string name, input int unsigned got, input int unsigned want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Monitor: pops on every output transfer and checks payload holds while stalled.
  initial begin : monitor
    exp_t e;
    exp_t got;
    exp_t held_v;
    logic held;
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge in_clk);
      got = {out_data, out_err_single, out_err_double, out_syndrome};
      if (out_valid) begin
        if (held) begin
          n_tests++;
          if (got != held_v) begin
            n_fail++;
            $display("FAIL stall_stable: got %h, required %h", got, held_v);
          end
        end
        if (in_ready) begin
          held = 1'b0;
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got %h, required no output", got);
          end else begin
            e = q.pop_front();
            if (got != e) begin
              n_fail++;
              $display("FAIL output: got data=%b s=%b d=%b syn=%0d, required data=%b s=%b d=%b syn=%0d",
                       got.data, got.single, got.dbl, got.syn, e.data, e.single, e.dbl, e.syn);
            end
          end
        end else begin
          held   = 1'b1;
          held_v = got;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic send(input logic [6:0] code, input logic par, input exp_t e);
    int unsigned n;
    n = 0;
    @(negedge in_clk);
    in_valid  = 1'b1;
    in_code   = code;
    in_parity = par;
    #1;
    while (!out_ready && n < 200) begin
      @(negedge in_clk);
      #1;
      n++;
    end
    if (!out_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got out_ready=0, required 1");
    end else begin
      q.push_back(e);
    end
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge in_clk);
    #2;
    in_ready = v;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge in_clk);
      n++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d words outstanding, required 0", q.size());
    end
    @(posedge in_clk);
    @(negedge in_clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [6:0] s_code [8];
    logic       s_par  [8];
    logic [3:0] s_data [8];
    int unsigned n;

    s_code = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h4B, 7'h7F, 7'h52};
    s_par  = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    s_data = '{4'h0,  4'h1,  4'h2,  4'h3,  4'h4,  4'h8,  4'hF,  4'hA};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_payload", {out_data, out_err_single, out_err_double, out_syndrome}, 0);
    chk("rst_cnt_single", out_cnt_single, 0);
    chk("rst_cnt_double", out_cnt_double, 0);
    @(negedge in_clk);
    in_rst = 1'b0;

    // 1: clean word and two-cycle latency
    send(7'h55, 1'b0, '{4'b1011, 1'b0, 1'b0, 3'd0});
    @(negedge in_clk);
    chk("latency_c1_valid", out_valid, 0);
    @(negedge in_clk);
    chk("latency_c2_valid", out_valid, 1);
    drain();

    // 2: position 5 flipped
    send(7'h45, 1'b0, '{4'b1011, 1'b1, 1'b0, 3'd5});
    drain();
    chk("cnt_single_after_t2", out_cnt_single, 1);

    // 3: positions 1 and 2 flipped
    send(7'h56, 1'b0, '{4'b1011, 1'b0, 1'b1, 3'd3});
    drain();
    chk("cnt_double_after_t3", out_cnt_double, 1);

    // 4: overall parity bit wrong
    send(7'h55, 1'b1, '{4'b1011, 1'b1, 1'b0, 3'd0});
    drain();
    chk("cnt_single_after_t4", out_cnt_single, 2);
    chk("cnt_double_after_t4", out_cnt_double, 1);

    // 5: back-to-back stream with in_ready toggling
    fork
      begin
        for (int i = 0; i < 8; i++) send(s_code[i], s_par[i], '{s_data[i], 1'b0, 1'b0, 3'd0});
      end
      begin
        repeat (40) begin
          @(posedge in_clk);
          #2;
          in_ready = ~in_ready;
        end
      end
    join
    drain();
    chk("cnt_single_after_stream", out_cnt_single, 2);

    // 6: reset with two words in flight
    set_ready(1'b0);
    send(7'h07, 1'b1, '{4'h1, 1'b0, 1'b0, 3'd0});
    send(7'h45, 1'b0, '{4'b1011, 1'b1, 1'b0, 3'd5});
    @(posedge in_clk);
    #3;
    in_rst = 1'b1;
    q.delete();
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_cnt_single", out_cnt_single, 0);
    chk("async_rst_cnt_double", out_cnt_double, 0);
    chk("async_rst_out_data", out_data, 0);
    @(negedge in_clk);
    in_rst = 1'b0;
    set_ready(1'b1);
    repeat (4) @(negedge in_clk);
    chk("post_rst_out_valid", out_valid, 0);

    // 7: CNT_W=2 instance saturates
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk);
      v2    = 1'b1;
      code2 = 7'h45;
    end
    @(negedge in_clk);
    v2 = 1'b0;
    repeat (4) @(negedge in_clk);
    chk("sat_cnt_single", cs2, 3);
    chk("sat_cnt_double", cd2, 0);

    // 8: clear coincident with a flagged transfer
    set_ready(1'b0);
    send(7'h45, 1'b0, '{4'b1011, 1'b1, 1'b0, 3'd5});
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge in_clk);
      n++;
    end
    chk("stalled_word_valid", out_valid, 1);
    chk("cnt_before_transfer", out_cnt_single, 0);
    set_ready(1'b1);
    in_cnt_clr = 1'b1;
    @(posedge in_clk);
    #2;
    in_cnt_clr = 1'b0;
    @(negedge in_clk);
    chk("clr_beats_inc", out_cnt_single, 0);
    chk("clr_word_gone", out_valid, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
